// File: rtl/ddr2_reset_sequencer.sv
// DDR2 subsystem reset/bring-up sequencer: PLL reset pulse, lock qualification,
// nested release of memory-controller and user-logic resets, calibration
// supervision, bounded retries and a sticky failure state.
module ddr2_reset_sequencer #(
  parameter int unsigned PLL_RST_CYC     = 4,
  parameter int unsigned LOCK_STABLE_CYC = 16,
  parameter int unsigned LOCK_TIMEOUT    = 1024,
  parameter int unsigned CORE_DELAY_CYC  = 100,
  parameter int unsigned CALIB_TIMEOUT   = 40000,
  parameter int unsigned MAX_RETRY       = 3,
  parameter int unsigned CNT_W           = 16
) (
  input  logic       clk,
  input  logic       rstN,
  input  logic       softRst,
  input  logic       pllLocked,
  input  logic       calibDone,
  output logic       pllRst,
  output logic       memRst,
  output logic       userRst,
  output logic       ready,
  output logic       fail,
  output logic [1:0] retryCnt,
  output logic [2:0] stateOut
);

  localparam int unsigned RETRY_W = 2;

  typedef enum logic [2:0] {
    PLL_RST    = 3'd0,
    WAIT_LOCK  = 3'd1,
    REL_CORE   = 3'd2,
    WAIT_CALIB = 3'd3,
    RUN        = 3'd4,
    FAIL       = 3'd5
  } state_t;

  state_t             state, state_nx;
  logic [CNT_W-1:0]   cnt, cnt_nx;
  logic [CNT_W-1:0]   stab, stab_nx;
  logic [RETRY_W-1:0] retry, retry_nx;
  logic               sync1, sync2;
  logic               retry_go;
  logic               pll_rst_nx, mem_rst_nx, user_rst_nx, ready_nx, fail_nx;

  // Two-flop synchronizer for the asynchronous PLL lock indication
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= pllLocked;
      sync2 <= sync1;
    end
  end

  // State, counters and registered reset outputs
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state   <= PLL_RST;
      cnt     <= '0;
      stab    <= '0;
      retry   <= '0;
      pllRst  <= 1'b1;
      memRst  <= 1'b1;
      userRst <= 1'b1;
      ready   <= 1'b0;
      fail    <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      stab    <= stab_nx;
      retry   <= retry_nx;
      pllRst  <= pll_rst_nx;
      memRst  <= mem_rst_nx;
      userRst <= user_rst_nx;
      ready   <= ready_nx;
      fail    <= fail_nx;
    end
  end

  // Next-state, counter and output decode; outputs follow the next state so
  // they change on the same edge as the state register
  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt + CNT_W'(1);
    stab_nx     = '0;
    retry_nx    = retry;
    retry_go    = 1'b0;
    pll_rst_nx  = 1'b0;
    mem_rst_nx  = 1'b1;
    user_rst_nx = 1'b1;
    ready_nx    = 1'b0;
    fail_nx     = 1'b0;

    case (state)
      PLL_RST: begin
        if (cnt == CNT_W'(PLL_RST_CYC - 1)) state_nx = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (sync2) stab_nx = stab + CNT_W'(1);
        // Stable lock takes priority over a coincident timeout
        if (sync2 && (stab == CNT_W'(LOCK_STABLE_CYC - 1))) state_nx = REL_CORE;
        else if (cnt == CNT_W'(LOCK_TIMEOUT - 1))           retry_go = 1'b1;
      end
      REL_CORE: begin
        if (!sync2)                                  state_nx = PLL_RST;
        else if (cnt == CNT_W'(CORE_DELAY_CYC - 1))  state_nx = WAIT_CALIB;
      end
      WAIT_CALIB: begin
        // Calibration completion takes priority over a coincident timeout
        if (!sync2)                                  state_nx = PLL_RST;
        else if (calibDone)                          state_nx = RUN;
        else if (cnt == CNT_W'(CALIB_TIMEOUT - 1))   retry_go = 1'b1;
      end
      RUN: begin
        cnt_nx = cnt;
        if (!sync2) state_nx = PLL_RST;
      end
      FAIL: begin
        cnt_nx = cnt;
      end
      default: begin
        state_nx = PLL_RST;
      end
    endcase

    // Retry path: bounded restarts, then park in FAIL with the count saturated
    if (retry_go) begin
      if (retry < RETRY_W'(MAX_RETRY)) begin
        retry_nx = retry + RETRY_W'(1);
        state_nx = PLL_RST;
      end else begin
        state_nx = FAIL;
      end
    end

    if (state_nx != state) begin
      cnt_nx  = '0;
      stab_nx = '0;
    end

    // Soft restart overrides everything and holds the counter at zero
    if (softRst) begin
      state_nx = PLL_RST;
      cnt_nx   = '0;
      stab_nx  = '0;
      retry_nx = '0;
    end

    case (state_nx)
      PLL_RST:    pll_rst_nx = 1'b1;
      WAIT_LOCK:  ;
      REL_CORE:   mem_rst_nx = 1'b0;
      WAIT_CALIB: mem_rst_nx = 1'b0;
      RUN: begin
        mem_rst_nx  = 1'b0;
        user_rst_nx = 1'b0;
        ready_nx    = 1'b1;
      end
      FAIL:       fail_nx = 1'b1;
      default:    pll_rst_nx = 1'b1;
    endcase
  end

  assign retryCnt = retry;
  assign stateOut = state;

endmodule
